// File: rtl/pc_sequencer.sv
// Bitty core instruction sequencer: owns the PC, fetches over req/ack, starts execute for non-branches, retires via the branch unit's new_pc.
// Optional single-step mode under `SINGLE_STEP_EN` (one retirement per step sampled in IDLE); all outputs registered or decoded from state.
module pc_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        step,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instruction,
    output logic        exec_start,
    input  logic        exec_done,
    input  logic [15:0] alu_result,
    output logic [15:0] last_alu_result,
    input  logic [7:0]  new_pc,
    output logic [7:0]  pc,
    output logic        busy,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t state;
    logic   start_ok;
    logic   continue_ok;

`ifdef SINGLE_STEP_EN
    assign start_ok    = run & step;
    assign continue_ok = 1'b0;
`else
    logic unused_step;
    assign unused_step = step;
    assign start_ok    = run;
    assign continue_ok = run;
`endif

    // The fetch address is the PC itself, so it is stable for the whole handshake.
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            pc              <= 8'h00;
            instruction     <= 16'h0000;
            last_alu_result <= 16'h0000;
            instr_count     <= 16'h0000;
            imem_req        <= 1'b0;
            exec_start      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_data;
                        imem_req    <= 1'b0;
                        // Branches skip the datapath; the branch unit alone resolves the next PC.
                        if (imem_data[1:0] == 2'b10) begin
                            state <= S_NEXT;
                        end else begin
                            state      <= S_EXEC;
                            exec_start <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    exec_start <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (exec_done) begin
                        last_alu_result <= alu_result;
                        state           <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    pc          <= new_pc;
                    instr_count <= instr_count + 16'd1;
                    if (continue_ok) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req   <= 1'b0;
                    exec_start <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: models imem, datapath and branch unit; a monitor checks every retirement against queued expectations.
module tb_pc_sequencer;

`ifdef SINGLE_STEP_EN
    localparam int   GAP      = 1;
    localparam logic STEP_DEF = 1'b1;
`else
    localparam int   GAP      = 0;
    localparam logic STEP_DEF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        step = STEP_DEF;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instruction;
    logic        exec_start;
    logic        exec_done;
    logic [15:0] alu_result;
    logic [15:0] last_alu_result;
    logic [7:0]  new_pc;
    logic [7:0]  pc;
    logic        busy;
    logic [15:0] instr_count;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .instruction(instruction), .exec_start(exec_start), .exec_done(exec_done),
        .alu_result(alu_result), .last_alu_result(last_alu_result), .new_pc(new_pc),
        .pc(pc), .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Branch unit model: branches jump to instr[15:8], everything else falls through.
    always_comb begin
        new_pc = pc + 8'd1;
        if (instruction[1:0] == 2'b10) new_pc = instruction[15:8];
    end

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] cnt;
        logic [15:0] last;
        int          starts;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] mem[256];
    int          ack_dly[256];
    int          done_dly[256];
    logic [15:0] alu_tab[256];
    bit          stray_ack = 1'b0;
    int          last_req_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [7:0] p, input logic [15:0] c, input logic [15:0] l, input int s, input int cy);
        exp_t e;
        e.pc = p; e.cnt = c; e.last = l; e.starts = s; e.cyc = cy;
        sb.push_back(e);
    endtask

    // Instruction memory: acks after a per-address delay, optional stray acks outside FETCH.
    initial begin
        int          wait_n;
        logic [7:0]  first_addr;
        wait_n = 0;
        first_addr = 8'h00;
        imem_ack = 1'b0;
        imem_data = 16'h0000;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            imem_data = 16'h0000;
            if (!reset && imem_req) begin
                if (wait_n == 0) first_addr = imem_addr;
                else check("imem_addr_stable", imem_addr, first_addr);
                if (wait_n == ack_dly[imem_addr]) begin
                    imem_ack = 1'b1;
                    imem_data = mem[imem_addr];
                    last_req_len = wait_n + 1;
                    wait_n = 0;
                end else begin
                    wait_n++;
                end
            end else begin
                wait_n = 0;
                if (stray_ack) begin
                    imem_ack = 1'b1;
                    imem_data = 16'hFFFF;
                end
            end
        end
    end

    // Datapath: done arrives done_dly[pc] cycles after the exec_start cycle.
    initial begin
        int          d;
        logic [15:0] v;
        exec_done = 1'b0;
        alu_result = 16'h0000;
        forever begin
            @(negedge clk);
            if (exec_start && !reset) begin
                d = done_dly[pc];
                v = alu_tab[pc];
                repeat (d) @(negedge clk);
                exec_done = 1'b1;
                alu_result = v;
                @(negedge clk);
                exec_done = 1'b0;
                alu_result = 16'h0000;
            end
        end
    end

    // Monitor: every change of instr_count is a retirement checked against the queue.
    initial begin
        int          starts_seen;
        int          cyc;
        logic [15:0] prev_cnt;
        exp_t        e;
        starts_seen = 0;
        cyc = 0;
        prev_cnt = 16'h0000;
        forever begin
            @(negedge clk);
            if (reset) begin
                starts_seen = 0;
                cyc = 0;
                prev_cnt = instr_count;
            end else begin
                cyc++;
                if (exec_start) starts_seen++;
                if (instr_count !== prev_cnt) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_retire actual_count=%0d required=none", instr_count);
                    end else begin
                        e = sb.pop_front();
                        check("retire_pc", pc, e.pc);
                        check("retire_count", instr_count, e.cnt);
                        check("retire_last_alu", last_alu_result, e.last);
                        check("retire_exec_starts", starts_seen, e.starts);
                        if (e.cyc >= 0) check("retire_cycles", cyc, e.cyc);
                    end
                    starts_seen = 0;
                    cyc = 0;
                    prev_cnt = instr_count;
                end
            end
        end
    end

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exec_start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout_exec_start actual=none required=pulse");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL timeout_retire actual_pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {pc, instruction, last_alu_result, instr_count, imem_req, exec_start, busy}, 59'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0000;
            ack_dly[i] = 0;
            done_dly[i] = 2;
            alu_tab[i] = 16'h0000;
        end
        mem[8'h00] = 16'h0001;  alu_tab[8'h00] = 16'h0005;
        mem[8'h01] = 16'h0A02;
        mem[8'h0A] = 16'h0003;  alu_tab[8'h0A] = 16'h0007; ack_dly[8'h0A] = 3; done_dly[8'h0A] = 3;
        mem[8'h0B] = 16'h0010;  alu_tab[8'h0B] = 16'h0009;
        mem[8'hFF] = 16'h0004;  alu_tab[8'hFF] = 16'h0003; done_dly[8'hFF] = 1;

        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_without_run_busy", busy, 1'b0);
        check("idle_without_run_req", imem_req, 1'b0);

        // Non-branch, branch to 0x0A, then delayed-ack instruction with run dropped in WAIT.
        push(8'h01, 16'd1, 16'h0005, 1, -1);
        push(8'h0A, 16'd2, 16'h0005, 0, 2 + GAP);
        push(8'h0B, 16'd3, 16'h0007, 1, 9 + GAP);
        @(posedge clk); #1;
        run = 1'b1;
        wait_start();
        wait_start();
        @(posedge clk); #1;
        run = 1'b0;
        stray_ack = 1'b1;
        wait_drain();
        repeat (3) @(negedge clk);
        stray_ack = 1'b0;
        check("run_drop_busy", busy, 1'b0);
        check("run_drop_pc", pc, 8'h0B);
        check("run_drop_req", imem_req, 1'b0);
        check("stray_ack_instruction", instruction, 16'h0003);
        check("delayed_ack_req_len", last_req_len, 4);

        // Re-run from the new PC, then reset while waiting for done.
        @(posedge clk); #1;
        run = 1'b1;
        for (int i = 0; i < 10 && !imem_req; i++) @(negedge clk);
        check("rerun_fetch_addr", {imem_req, imem_addr}, {1'b1, 8'h0B});
        wait_start();
        @(posedge clk); #1;
        reset = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check_all_zero("reset_in_wait");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("late_done_ignored", {last_alu_result, busy, instr_count}, 33'h0);

        // Branch to 0xFF, then fall-through wraps the PC to 0.
        mem[8'h00] = 16'hFF02;
        push(8'hFF, 16'd1, 16'h0000, 0, -1);
        push(8'h00, 16'd2, 16'h0003, 1, 4 + GAP);
        @(posedge clk); #1;
        run = 1'b1;
        wait_start();
        @(posedge clk); #1;
        run = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);
        check("wrap_pc", pc, 8'h00);
        check("wrap_busy", busy, 1'b0);

`ifdef SINGLE_STEP_EN
        mem[8'h00] = 16'h0001;
        mem[8'h01] = 16'h0001;  alu_tab[8'h01] = 16'h0011;
        mem[8'h02] = 16'h0001;  alu_tab[8'h02] = 16'h0012;
        step = 1'b0;
        pulse_reset();
        push(8'h01, 16'd1, 16'h0005, 1, -1);
        push(8'h02, 16'd2, 16'h0011, 1, -1);
        push(8'h03, 16'd3, 16'h0012, 1, -1);
        run = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            for (int i = 0; i < 30 && busy; i++) @(negedge clk);
            repeat (3) @(negedge clk);
            check("step_idle_between", busy, 1'b0);
        end
        wait_drain();
        check("step_count", instr_count, 16'd3);
        run = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
